id_ex_hazard_stage: RTL and testbench
=====================================

Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register plus load-use hazard detection, directly upstream of the forwarding unit.
- Captures decoded fields (rs, rt, rd, reg-write, load flag, operands) each cycle and presents them as RS/RT/ID_EX_RD and data to EX and forwarding.
- Detects load-use dependencies forwarding cannot resolve. Stalls PC and IF/ID, inserts bubbles, honours branch flush and memory hold.

Parameters:
- REG_AW, 4, register address width (16-entry register file).
- DATA_W, 16, operand/immediate width.
- OP_W, 4, ALU opcode width.
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (1..3).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt, id_rd  in  REG_AW  decoded register addresses.
- id_use_rs, id_use_rt  in  1  instruction reads rs / rt.
- id_rw  in  1  instruction writes rd.
- id_mem_rd  in  1  instruction is a load.
- id_rs_data, id_rt_data, id_imm  in  DATA_W  operands.
- id_alu_op  in  OP_W  ALU opcode.
- flush  in  1  branch taken in EX; squash ID/EX.
- mem_hold  in  1  memory busy; freeze pipeline.
- ex_valid, ex_rw, ex_mem_rd  out  1  registered control.
- ex_rs, ex_rt, ex_rd  out  REG_AW  registered addresses (feed forwarding RS/RT/ID_EX_RD).
- ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered operands.
- ex_alu_op  out  OP_W  registered opcode.
- pc_stall, if_id_stall  out  1  hold PC and IF/ID (combinational).

Behaviour:
- Reset: all ex_* outputs 0; FSM in RUN; bubble counter 0; stalls 0 while rst is high.
- Hazard (combinational), asserted when all hold:
  - ex_valid & ex_mem_rd & ex_rw & id_valid
  - ((id_use_rs & ex_rd==id_rs) | (id_use_rt & ex_rd==id_rt))
  - No special case for register 0.
- Bubble: ex_valid=ex_rw=ex_mem_rd=0. Address, data and opcode fields become 0.
- FSM state RUN:
  - hazard=1: load bubble and assert stalls. If LOAD_USE_BUBBLES>1, go to BUBBLE with cnt=LOAD_USE_BUBBLES-1; otherwise stay in RUN.
  - hazard=0: load ID fields, with ex_valid=id_valid and ex_rw/ex_mem_rd gated by id_valid.
- FSM state BUBBLE:
  - Load bubble, assert stalls, cnt--.
  - At cnt==1 (before decrement), return to RUN. The next cycle accepts the held ID instruction.
- Stalls: pc_stall = if_id_stall = mem_hold | (RUN & hazard) | BUBBLE.
- Priority at each edge: rst > flush > mem_hold > hazard > normal.
  - flush: load bubble, FSM to RUN, cnt=0, no stall from this block that cycle (IF/ID is squashed upstream).
  - mem_hold (no flush): all registers, FSM and counter hold their values.
  - flush and mem_hold together: flush wins.
- Latency: one cycle from ID to ex_*. A load-use pair is separated by exactly LOAD_USE_BUBBLES bubble cycles.
- A hazard on both rs and rt from the same load counts as one hazard (same bubble count).
- Reset asserted mid-BUBBLE: next state is RUN with outputs cleared.

Decomposition:
- Shared package: REG_AW, DATA_W and OP_W defaults; a bubble-constant struct/typedef for the ID/EX bundle.
- Shared with the forwarding unit and EX/MEM stage: RUN/BUBBLE state encoding.
- One natural sub-module, load_use_detect: purely combinational hazard compare. The register and FSM stay in the parent.

Test Plan:
1. Independent ops: ADD r1,r2,r3 then ADD r4,r5,r6 -> ex_* update each cycle; stalls 0 throughout.
2. Load then use:
   - Stimulus: LD r5 (ex_rd=5, ex_mem_rd=1), then ADD with id_rs=5, id_use_rs=1.
   - Required response: one cycle pc_stall=if_id_stall=1 and ex_valid=0; next cycle ex_rs=5, ex_valid=1.
   - Repeat with LOAD_USE_BUBBLES=3 -> exactly 3 bubble cycles.
3. Load then non-use:
   - LD r5, then ADD with id_rt=5 and id_use_rt=0 -> no stall.
   - LD r5 with ex_rw=0 -> no stall.
4. Flush mid-bubble (LOAD_USE_BUBBLES=3): flush on 2nd bubble cycle -> next cycle FSM in RUN, ex_valid=0, stalls 0, ID instruction then accepted normally.
5. mem_hold=1 for 4 cycles during BUBBLE with cnt=2 -> ex_* and cnt frozen, stalls 1. After release, 2 more bubble cycles, then the instruction enters.
6. rst=1 with ex_* nonzero and FSM in BUBBLE -> next edge all ex_*=0, stalls 0, RUN; rst and flush together -> reset values.

Source files
------------

// File: rtl/id_ex_hazard_stage_pkg.sv
// Shared definitions for the ID/EX register, load-use detection and the
// neighbouring forwarding / EX/MEM stages.
package id_ex_hazard_stage_pkg;

    localparam int DEF_REG_AW = 4;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_OP_W   = 4;

    // Pipeline-control state encoding shared with forwarding and EX/MEM.
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } pipe_state_t;

    typedef struct packed {
        logic                  valid;
        logic                  rw;
        logic                  mem_rd;
        logic [DEF_REG_AW-1:0] rs;
        logic [DEF_REG_AW-1:0] rt;
        logic [DEF_REG_AW-1:0] rd;
        logic [DEF_DATA_W-1:0] rs_data;
        logic [DEF_DATA_W-1:0] rt_data;
        logic [DEF_DATA_W-1:0] imm;
        logic [DEF_OP_W-1:0]   alu_op;
    } idex_bundle_t;

    // A bubble is an all-zero ID/EX bundle.
    localparam idex_bundle_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_hazard_stage_load_use_detect.sv
// Combinational load-use compare: the load sitting in EX targets a register
// the instruction in ID is about to read. Register 0 is not special.
module load_use_detect #(
    parameter int REG_AW = 4
) (
    input  logic              i_ex_valid,
    input  logic              i_ex_rw,
    input  logic              i_ex_mem_rd,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    input  logic              i_id_use_rs,
    input  logic              i_id_use_rt,
    output logic              o_hazard
);

    logic w_ex_is_load;
    logic w_match;

    assign w_ex_is_load = i_ex_valid & i_ex_mem_rd & i_ex_rw & i_id_valid;
    assign w_match      = (i_id_use_rs & (i_ex_rd == i_id_rs)) |
                          (i_id_use_rt & (i_ex_rd == i_id_rt));
    assign o_hazard     = w_ex_is_load & w_match;

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall/bubble control, branch flush
// and memory-hold freeze.
module id_ex_hazard_stage
    import id_ex_hazard_stage_pkg::*;
#(
    parameter int REG_AW           = DEF_REG_AW,
    parameter int DATA_W           = DEF_DATA_W,
    parameter int OP_W             = DEF_OP_W,
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_rw,
    input  logic              id_mem_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [OP_W-1:0]   id_alu_op,
    input  logic              flush,
    input  logic              mem_hold,
    output logic              ex_valid,
    output logic              ex_rw,
    output logic              ex_mem_rd,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [OP_W-1:0]   ex_alu_op,
    output logic              pc_stall,
    output logic              if_id_stall
);

    localparam int              CNT_W    = 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_USE_BUBBLES - 1);

    pipe_state_t       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_valid;
    logic              r_rw;
    logic              r_mem_rd;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [OP_W-1:0]   r_alu_op;

    logic              w_hazard;
    logic              w_load_bubble;
    logic              w_load_id;
    pipe_state_t       w_state_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_stall;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .i_ex_valid  (r_valid),
        .i_ex_rw     (r_rw),
        .i_ex_mem_rd (r_mem_rd),
        .i_ex_rd     (r_rd),
        .i_id_valid  (id_valid),
        .i_id_rs     (id_rs),
        .i_id_rt     (id_rt),
        .i_id_use_rs (id_use_rs),
        .i_id_use_rt (id_use_rt),
        .o_hazard    (w_hazard)
    );

    // Next-state decision in priority order: flush, hold, then FSM.
    always_comb begin
        w_load_bubble = 1'b0;
        w_load_id     = 1'b0;
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        if (flush) begin
            w_load_bubble = 1'b1;
            w_state_next  = ST_RUN;
            w_cnt_next    = '0;
        end else if (!mem_hold) begin
            case (r_state)
                ST_RUN: begin
                    if (w_hazard) begin
                        w_load_bubble = 1'b1;
                        if (LOAD_USE_BUBBLES > 1) begin
                            w_state_next = ST_BUBBLE;
                            w_cnt_next   = CNT_LOAD;
                        end
                    end else begin
                        w_load_id = 1'b1;
                    end
                end
                ST_BUBBLE: begin
                    w_load_bubble = 1'b1;
                    w_cnt_next    = r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_next = ST_RUN;
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_load_bubble) begin
            r_valid   <= 1'b0;
            r_rw      <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_alu_op  <= '0;
        end else if (w_load_id) begin
            r_valid   <= id_valid;
            r_rw      <= id_rw & id_valid;
            r_mem_rd  <= id_mem_rd & id_valid;
            r_rs      <= id_rs;
            r_rt      <= id_rt;
            r_rd      <= id_rd;
            r_rs_data <= id_rs_data;
            r_rt_data <= id_rt_data;
            r_imm     <= id_imm;
            r_alu_op  <= id_alu_op;
        end
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // A flush squashes IF/ID upstream, so this block does not also stall it.
    assign w_stall = !rst && !flush &&
                     (mem_hold || (r_state == ST_RUN && w_hazard) || r_state == ST_BUBBLE);

    assign pc_stall    = w_stall;
    assign if_id_stall = w_stall;

    assign ex_valid   = r_valid;
    assign ex_rw      = r_rw;
    assign ex_mem_rd  = r_mem_rd;
    assign ex_rs      = r_rs;
    assign ex_rt      = r_rt;
    assign ex_rd      = r_rd;
    assign ex_rs_data = r_rs_data;
    assign ex_rt_data = r_rt_data;
    assign ex_imm     = r_imm;
    assign ex_alu_op  = r_alu_op;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage: one instance with a single load-use
// bubble and one with three, each step checked against a scoreboard entry.
module tb_id_ex_hazard_stage;

    typedef struct packed {
        logic        valid;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [3:0]  rd;
        logic        use_rs;
        logic        use_rt;
        logic        rw;
        logic        mem_rd;
        logic [15:0] rs_data;
        logic [15:0] rt_data;
        logic [15:0] imm;
        logic [3:0]  op;
    } instr_t;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        mem_rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [3:0]  rd;
        logic [15:0] rs_data;
        logic [15:0] rt_data;
        logic [15:0] imm;
        logic [3:0]  op;
    } out_t;

    typedef struct packed {
        logic stall;
        out_t ex;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    instr_t in_a = '0, in_b = '0;
    logic   flush_a = 1'b0, hold_a = 1'b0, flush_b = 1'b0, hold_b = 1'b0;

    logic        ex_valid_a, ex_rw_a, ex_mem_rd_a, pc_stall_a, if_id_stall_a;
    logic [3:0]  ex_rs_a, ex_rt_a, ex_rd_a, ex_op_a;
    logic [15:0] ex_rs_data_a, ex_rt_data_a, ex_imm_a;
    logic        ex_valid_b, ex_rw_b, ex_mem_rd_b, pc_stall_b, if_id_stall_b;
    logic [3:0]  ex_rs_b, ex_rt_b, ex_rd_b, ex_op_b;
    logic [15:0] ex_rs_data_b, ex_rt_data_b, ex_imm_b;

    out_t out_a, out_b;
    assign out_a = '{ex_valid_a, ex_rw_a, ex_mem_rd_a, ex_rs_a, ex_rt_a, ex_rd_a,
                     ex_rs_data_a, ex_rt_data_a, ex_imm_a, ex_op_a};
    assign out_b = '{ex_valid_b, ex_rw_b, ex_mem_rd_b, ex_rs_b, ex_rt_b, ex_rd_b,
                     ex_rs_data_b, ex_rt_data_b, ex_imm_b, ex_op_b};

    always #5 clk = ~clk;

    id_ex_hazard_stage #(.LOAD_USE_BUBBLES(1)) dut_a (
        .clk(clk), .rst(rst),
        .id_valid(in_a.valid), .id_rs(in_a.rs), .id_rt(in_a.rt), .id_rd(in_a.rd),
        .id_use_rs(in_a.use_rs), .id_use_rt(in_a.use_rt),
        .id_rw(in_a.rw), .id_mem_rd(in_a.mem_rd),
        .id_rs_data(in_a.rs_data), .id_rt_data(in_a.rt_data), .id_imm(in_a.imm),
        .id_alu_op(in_a.op), .flush(flush_a), .mem_hold(hold_a),
        .ex_valid(ex_valid_a), .ex_rw(ex_rw_a), .ex_mem_rd(ex_mem_rd_a),
        .ex_rs(ex_rs_a), .ex_rt(ex_rt_a), .ex_rd(ex_rd_a),
        .ex_rs_data(ex_rs_data_a), .ex_rt_data(ex_rt_data_a), .ex_imm(ex_imm_a),
        .ex_alu_op(ex_op_a), .pc_stall(pc_stall_a), .if_id_stall(if_id_stall_a)
    );

    id_ex_hazard_stage #(.LOAD_USE_BUBBLES(3)) dut_b (
        .clk(clk), .rst(rst),
        .id_valid(in_b.valid), .id_rs(in_b.rs), .id_rt(in_b.rt), .id_rd(in_b.rd),
        .id_use_rs(in_b.use_rs), .id_use_rt(in_b.use_rt),
        .id_rw(in_b.rw), .id_mem_rd(in_b.mem_rd),
        .id_rs_data(in_b.rs_data), .id_rt_data(in_b.rt_data), .id_imm(in_b.imm),
        .id_alu_op(in_b.op), .flush(flush_b), .mem_hold(hold_b),
        .ex_valid(ex_valid_b), .ex_rw(ex_rw_b), .ex_mem_rd(ex_mem_rd_b),
        .ex_rs(ex_rs_b), .ex_rt(ex_rt_b), .ex_rd(ex_rd_b),
        .ex_rs_data(ex_rs_data_b), .ex_rt_data(ex_rt_data_b), .ex_imm(ex_imm_b),
        .ex_alu_op(ex_op_b), .pc_stall(pc_stall_b), .if_id_stall(if_id_stall_b)
    );

    int    n_vec = 0;
    int    n_err = 0;
    exp_t  exp_q[$];
    string tag_q[$];

    function automatic instr_t mk(input logic [3:0] rs, input logic [3:0] rt,
                                  input logic [3:0] rd, input logic urs, input logic urt,
                                  input logic rw, input logic ld, input logic [15:0] a,
                                  input logic [15:0] b, input logic [15:0] imm,
                                  input logic [3:0] op);
        instr_t i;
        i = '{1'b1, rs, rt, rd, urs, urt, rw, ld, a, b, imm, op};
        return i;
    endfunction

    // Expected ex_* after an instruction is accepted into EX.
    function automatic out_t acc(input instr_t i);
        out_t o;
        o = '{i.valid, i.rw & i.valid, i.mem_rd & i.valid, i.rs, i.rt, i.rd,
              i.rs_data, i.rt_data, i.imm, i.op};
        return o;
    endfunction

    task automatic step(input bit sel, input instr_t ins, input logic fl, input logic hd,
                        input logic r, input logic es, input out_t ee, input string tag);
        exp_t  e;
        string t;
        logic  obs_pc, obs_ifid;
        out_t  obs;
        @(negedge clk);
        rst = r;
        if (sel) begin
            in_b = ins; flush_b = fl; hold_b = hd;
            in_a = '0;  flush_a = 1'b0; hold_a = 1'b0;
        end else begin
            in_a = ins; flush_a = fl; hold_a = hd;
            in_b = '0;  flush_b = 1'b0; hold_b = 1'b0;
        end
        e.stall = es;
        e.ex    = ee;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        obs_pc   = sel ? pc_stall_b : pc_stall_a;
        obs_ifid = sel ? if_id_stall_b : if_id_stall_a;
        n_vec++;
        assert (obs_pc === exp_q[0].stall) else begin
            n_err++;
            $error("FAIL %s pc_stall observed=%b expected=%b", tag, obs_pc, exp_q[0].stall);
        end
        n_vec++;
        assert (obs_ifid === exp_q[0].stall) else begin
            n_err++;
            $error("FAIL %s if_id_stall observed=%b expected=%b", tag, obs_ifid, exp_q[0].stall);
        end
        @(posedge clk);
        #1;
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        obs = sel ? out_b : out_a;
        n_vec++;
        assert (obs === e.ex) else begin
            n_err++;
            $error("FAIL %s ex observed=%h expected=%h", t, obs, e.ex);
        end
        $display("[%s] dut=%0d stall=%b ex=%h", t, sel, obs_pc, obs);
    endtask

    initial begin
        instr_t add1, add2, ld5, addu, addn, ld5nw, addb, ld0, use0, inv;
        out_t   z;
        z     = '0;
        add1  = mk(4'd2, 4'd3, 4'd1, 1, 1, 1, 0, 16'h1111, 16'h2222, 16'h0003, 4'h1);
        add2  = mk(4'd5, 4'd6, 4'd4, 1, 1, 1, 0, 16'h3333, 16'h4444, 16'h0005, 4'h2);
        ld5   = mk(4'd1, 4'd0, 4'd5, 1, 0, 1, 1, 16'h1000, 16'h0000, 16'h0040, 4'h0);
        addu  = mk(4'd5, 4'd7, 4'd8, 1, 1, 1, 0, 16'hAAAA, 16'h5555, 16'h0000, 4'h1);
        addn  = mk(4'd2, 4'd5, 4'd9, 1, 0, 1, 0, 16'h0102, 16'h0304, 16'h0007, 4'h3);
        ld5nw = ld5;
        ld5nw.rw = 1'b0;
        addb  = mk(4'd5, 4'd5, 4'd10, 1, 1, 1, 0, 16'hBEEF, 16'hCAFE, 16'h0000, 4'h4);
        ld0   = mk(4'd3, 4'd0, 4'd0, 1, 0, 1, 1, 16'h2000, 16'h0000, 16'h0008, 4'h0);
        use0  = mk(4'd0, 4'd4, 4'd11, 1, 0, 1, 0, 16'h0F0F, 16'hF0F0, 16'h0001, 4'h5);
        inv   = add1;
        inv.valid = 1'b0;

        // Single-bubble instance
        step(0, add1,  0, 0, 1, 0, z,          "a_reset");
        step(0, add1,  0, 0, 0, 0, acc(add1),  "a_add1");
        step(0, add2,  0, 0, 0, 0, acc(add2),  "a_add2");
        step(0, ld5,   0, 0, 0, 0, acc(ld5),   "a_ld5");
        step(0, addu,  0, 0, 0, 1, z,          "a_lu_bubble");
        step(0, addu,  0, 0, 0, 0, acc(addu),  "a_lu_accept");
        step(0, ld5,   0, 0, 0, 0, acc(ld5),   "a_ld5_b");
        step(0, addn,  0, 0, 0, 0, acc(addn),  "a_nonuse_rt");
        step(0, ld5nw, 0, 0, 0, 0, acc(ld5nw), "a_ld_norw");
        step(0, addu,  0, 0, 0, 0, acc(addu),  "a_norw_nostall");
        step(0, ld5,   0, 0, 0, 0, acc(ld5),   "a_ld5_c");
        step(0, addb,  0, 0, 0, 1, z,          "a_both_bubble");
        step(0, addb,  0, 0, 0, 0, acc(addb),  "a_both_accept");
        step(0, ld0,   0, 0, 0, 0, acc(ld0),   "a_ld0");
        step(0, use0,  0, 0, 0, 1, z,          "a_r0_bubble");
        step(0, use0,  0, 0, 0, 0, acc(use0),  "a_r0_accept");
        step(0, inv,   0, 0, 0, 0, acc(inv),   "a_invalid");
        step(0, ld5,   0, 0, 0, 0, acc(ld5),   "a_ld5_d");
        step(0, addu,  0, 1, 0, 1, acc(ld5),   "a_hold_freeze");
        step(0, addu,  0, 0, 0, 1, z,          "a_hold_then_bubble");
        step(0, addu,  0, 0, 0, 0, acc(addu),  "a_hold_accept");
        step(0, ld5,   0, 0, 0, 0, acc(ld5),   "a_ld5_e");
        step(0, addu,  1, 0, 0, 0, z,          "a_flush");
        step(0, addu,  0, 0, 0, 0, acc(addu),  "a_flush_accept");
        step(0, add1,  0, 0, 0, 0, acc(add1),  "a_add1_b");
        step(0, add2,  1, 0, 1, 0, z,          "a_rst_flush");
        step(0, add1,  0, 0, 0, 0, acc(add1),  "a_add1_c");
        step(0, add2,  1, 1, 0, 0, z,          "a_flush_hold");

        // Three-bubble instance
        step(1, add1,  0, 0, 1, 0, z,          "b_reset");
        step(1, add1,  0, 0, 0, 0, acc(add1),  "b_add1");
        step(1, ld5,   0, 0, 0, 0, acc(ld5),   "b_ld5");
        for (int i = 0; i < 3; i++) step(1, addu, 0, 0, 0, 1, z, "b_lu_bubble");
        step(1, addu,  0, 0, 0, 0, acc(addu),  "b_lu_accept");
        step(1, ld5,   0, 0, 0, 0, acc(ld5),   "b_ld5_b");
        step(1, addu,  0, 0, 0, 1, z,          "b_flush_bub1");
        step(1, addu,  1, 0, 0, 0, z,          "b_flush_mid");
        step(1, addu,  0, 0, 0, 0, acc(addu),  "b_flush_accept");
        step(1, ld5,   0, 0, 0, 0, acc(ld5),   "b_ld5_c");
        step(1, addu,  0, 0, 0, 1, z,          "b_hold_bub1");
        for (int i = 0; i < 4; i++) step(1, addu, 0, 1, 0, 1, z, "b_hold_frozen");
        for (int i = 0; i < 2; i++) step(1, addu, 0, 0, 0, 1, z, "b_hold_resume");
        step(1, addu,  0, 0, 0, 0, acc(addu),  "b_hold_accept");
        step(1, ld5,   0, 0, 0, 0, acc(ld5),   "b_ld5_d");
        step(1, addu,  0, 0, 0, 1, z,          "b_rst_bub1");
        step(1, addu,  0, 0, 1, 0, z,          "b_rst_mid");
        step(1, addu,  0, 0, 0, 0, acc(addu),  "b_rst_accept");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
